// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run/halt/step sequencer with retired-instruction counter
// Optional breakpoint comparator is built when BRKPT_EN is defined.
module run_ctrl #(
  parameter int              PC_W        = 5,
  parameter int              IW          = 16,
  parameter logic [IW-1:0]   HALT_OPCODE = 16'hFFFF,
  parameter int              CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             HALT_REQ,
  input  logic             STEP_REQ,
  input  logic             CNT_CLR,
  input  logic [PC_W-1:0]  PC_IN,
  input  logic [IW-1:0]    PM_WORD,
  input  logic [PC_W-1:0]  BP_ADDR,
  input  logic             BP_VALID,
  output logic             CORE_EN,
  output logic [1:0]       STATE,
  output logic             HALTED,
  output logic [1:0]       HALT_CAUSE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [1:0] C_NONE   = 2'd0;
  localparam logic [1:0] C_REQ    = 2'd1;
  localparam logic [1:0] C_OPCODE = 2'd2;
  localparam logic [1:0] C_BRKPT  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [1:0]       halt_cause, cause_nxt;
  logic [CNT_W-1:0] instr_cnt;
  logic             op_hit;
  logic             bp_hit;
  logic             core_en;

  assign op_hit = (PM_WORD == HALT_OPCODE);

`ifdef BRKPT_EN
  logic bp_skip;

  // bp_skip lets a resume at the breakpoint PC retire that instruction once
  assign bp_hit = BP_VALID && (PC_IN == BP_ADDR) && (state == S_RUN) && !bp_skip;

  always_ff @(posedge CLK) begin
    if (RST)
      bp_skip <= 1'b0;
    else
      bp_skip <= (state == S_HALT) && START;
  end
`else
  logic unused_bp;

  assign unused_bp = ^{BP_ADDR, BP_VALID};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    core_en = 1'b0;
    case (state)
      S_RUN:   core_en = !op_hit && !bp_hit;
      S_STEP:  core_en = !op_hit;
      default: core_en = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = halt_cause;
    case (state)
      S_IDLE: begin
        if (START)
          state_nxt = S_RUN;
        else if (STEP_REQ)
          state_nxt = S_STEP;
      end
      S_RUN: begin
        if (op_hit) begin
          state_nxt = S_HALT;
          cause_nxt = C_OPCODE;
        end else if (bp_hit) begin
          state_nxt = S_HALT;
          cause_nxt = C_BRKPT;
        end else if (HALT_REQ) begin
          state_nxt = S_HALT;
          cause_nxt = C_REQ;
        end
      end
      S_STEP: begin
        state_nxt = S_HALT;
        cause_nxt = op_hit ? C_OPCODE : C_REQ;
      end
      default: begin
        if (START) begin
          state_nxt = S_RUN;
          cause_nxt = C_NONE;
        end else if (STEP_REQ) begin
          state_nxt = S_STEP;
          cause_nxt = C_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      halt_cause <= C_NONE;
      instr_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      halt_cause <= cause_nxt;
      if (CNT_CLR)
        instr_cnt <= '0;
      else if (core_en && (instr_cnt != {CNT_W{1'b1}}))
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign CORE_EN    = core_en;
  assign STATE      = state;
  assign HALTED     = (state == S_HALT);
  assign HALT_CAUSE = halt_cause;
  assign INSTR_CNT  = instr_cnt;

endmodule
